// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin scheduler sharing one combinational 8-bit ALU
// among NREQ requesters, returning tagged results on a valid/ready channel.
`default_nettype none

module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    input  logic [2*NREQ-1:0] req_op,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [1:0]        alu_op,
    output logic              alu_oe,
    input  logic [7:0]        alu_y,
    input  logic [4:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_y,
    output logic [4:0]        rsp_flags,
    output logic              busy,
    output logic [CNTW-1:0]   op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   rr_ptr_q;
    logic [7:0]       alu_a_q;
    logic [7:0]       alu_b_q;
    logic [1:0]       alu_op_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [7:0]       rsp_y_q;
    logic [4:0]       rsp_flags_q;
    logic [CNTW-1:0]  op_count_q;

    logic             grant_valid;
    logic [IDW-1:0]   grant_idx;
    logic             can_accept;
    logic             accept;
    logic             rsp_fire;
    logic [7:0]       sel_a;
    logic [7:0]       sel_b;
    logic [1:0]       sel_op;

    // Search downward in distance so the nearest requester after rr_ptr wins.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    // Gating with rst_n keeps req_ready low while reset is held.
    assign can_accept = rst_n &&
                        ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                req_ready[i] = can_accept && grant_valid;
                sel_a        = req_a[i*8 +: 8];
                sel_b        = req_b[i*8 +: 8];
                sel_op       = req_op[i*2 +: 2];
            end
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign rsp_fire = rsp_valid_q && rsp_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = accept ? S_EXEC : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_d == S_RESP);
            if (accept) begin
                alu_a_q  <= sel_a;
                alu_b_q  <= sel_b;
                alu_op_q <= sel_op;
                rsp_id_q <= grant_idx;
                rr_ptr_q <= grant_idx;
            end
            if (state_q == S_EXEC) begin
                rsp_y_q     <= alu_y;
                rsp_flags_q <= alu_flags;
            end
            if (rsp_fire && (op_count_q != {CNTW{1'b1}})) begin
                op_count_q <= op_count_q + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_oe    = (state_q == S_EXEC);
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state_q != S_IDLE);
    assign op_count  = op_count_q;

endmodule

`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Round-robin scheduler that shares one 8-bit combinational ALU (clk/oe/a/b/op in; y, parity, overflow, greater, is_eq, less out) among NREQ requesters.
- Accepts one request per grant, drives and holds the ALU operands for one evaluation cycle, then registers the result and flags.
- Returns the registered result on a valid/ready response channel tagged with the requester ID.
- Sits between the per-client command ports and the single ALU instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  8*NREQ  operand a; slice i belongs to requester i.
- req_b  in  8*NREQ  operand b; slice i belongs to requester i.
- req_op  in  2*NREQ  ALU op code; slice i belongs to requester i.
- alu_a  out  8  registered operand a to the ALU.
- alu_b  out  8  registered operand b to the ALU.
- alu_op  out  2  registered op to the ALU.
- alu_oe  out  1  ALU output enable; 1 only in EXEC.
- alu_y  in  8  ALU result.
- alu_flags  in  5  {parity, overflow, greater, is_eq, less} from the ALU.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_y  out  8  captured result.
- rsp_flags  out  5  captured flags, same bit order as alu_flags.
- busy  out  1  high in EXEC or RESP.
- op_count  out  CNTW  completed responses; saturates at all-ones.

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE, rr_ptr=NREQ-1, and all of the following are 0: req_ready, alu_a, alu_b, alu_op, alu_oe, rsp_valid, rsp_id, rsp_y, rsp_flags, busy, op_count.
- Asserting reset mid-operation discards the in-flight request and any pending response; no partial response is ever issued.
- Arbitration (combinational):
  - grant = first i with req_valid[i], searching from rr_ptr+1 upward modulo NREQ.
  - req_ready[grant]=1 only when state==IDLE, or when state==RESP and rsp_ready==1.
  - All other req_ready bits are 0.
- Accept edge (req_valid[g] & req_ready[g]):
  - latch alu_a, alu_b, alu_op from slice g;
  - latch rsp_id<=g and rr_ptr<=g;
  - state<=EXEC.
- EXEC (exactly 1 cycle):
  - alu_oe=1; operands held stable.
  - On the next edge: rsp_y<=alu_y, rsp_flags<=alu_flags, rsp_valid<=1, state<=RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_y and rsp_flags are held until rsp_valid & rsp_ready.
  - On handshake: op_count increments (saturating).
  - If a new request is granted in the same cycle, go directly to EXEC (back-to-back); rsp_valid falls for exactly one cycle.
  - Otherwise go to IDLE and clear rsp_valid.
- Latency: accept at edge T -> rsp_valid high after edge T+1. Peak throughput is one op per 2 cycles.
- alu_oe=0 in IDLE and RESP. alu_a, alu_b and alu_op keep their last values in those states; they are not cleared.
- Requesters may drop req_valid before they are granted; the arbiter samples only at the accept edge.
- Payload of a granted requester must be stable in its accept cycle only.
- busy = (state != IDLE).
- Illegal state encodings recover to IDLE.

Test Plan:
- Single op: req0 with a=8'h05, b=8'h03, op=2'b00 at T -> alu_oe=1 during T+1; after edge T+1, rsp_valid=1, rsp_id=0, rsp_y and rsp_flags equal the ALU model output for (05,03,00); op_count=1 after the handshake.
- Fairness: req0..req3 all held valid with rsp_ready=1 -> grant order 0,1,2,3,0; each requester gets one accept per 8 cycles.
- Backpressure: rsp_ready=0 for 5 cycles with req1 pending -> rsp_y and rsp_flags stay stable, req_ready=0 throughout; req1 is accepted in the cycle rsp_ready rises.
- Edge values: a=8'hFF, b=8'h01 and a=8'h80, b=8'h80 on every op -> rsp_y and rsp_flags (overflow, is_eq) match the model bit-exact.
- Reset mid-EXEC: rst_n low during EXEC -> rsp_valid, alu_oe and op_count are 0 immediately; after release the first grant goes to req0.
- Saturation: CNTW=4, 20 completions -> op_count holds at 4'hF.
